// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue slice: ALU op encoding,
// request function codes, response flag bit positions and stage states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010
    } alu_op_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } stage_t;

    localparam logic [3:0] FUNC_AND = 4'd0;
    localparam logic [3:0] FUNC_ADD = 4'd1;
    localparam logic [3:0] FUNC_SUB = 4'd2;

    // rsp_flags = {overflow, equal, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_EQUAL = 1;
    localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/alu_issue_dec.sv
// Request function decoder: maps req_func onto an ALU op and flags
// unsupported codes. Illegal codes fall back to AND so the ALU still sees a
// defined op; the result is discarded downstream.
module alu_issue_dec
    import alu_pkg::*;
(
    input  logic [3:0] req_func,
    output alu_op_t    op_o,
    output logic       illegal_o
);

    // Pure table lookup, no state.
    always_comb begin
        op_o      = ALU_AND;
        illegal_o = 1'b0;
        case (req_func)
            FUNC_AND: op_o = ALU_AND;
            FUNC_ADD: op_o = ALU_ADD;
            FUNC_SUB: op_o = ALU_SUB;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/response wrapper around an external combinational ALU.
// ISSUE holds the decoded request and drives the ALU; RESP captures the
// ALU result and flags and holds them until the consumer takes them.
// Optional feature macro: ALU_ISSUE_STICKY_OVF_EN adds ovf_clear/ovf_sticky.
//
// Stage states (same for ISSUE and RESP):
//   state    | meaning
//   ST_EMPTY | no operation held
//   ST_HOLD  | operation held, waiting to advance / be consumed
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_func,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_z,
    input  logic        alu_overflow,
    input  logic        alu_equal,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic [2:0]  rsp_flags,
    output logic        rsp_illegal,
    output logic [15:0] op_count
`ifdef ALU_ISSUE_STICKY_OVF_EN
    ,
    input  logic        ovf_clear,
    output logic        ovf_sticky
`endif
);

    stage_t      issue_st_q, issue_st_d;
    alu_op_t     issue_op_q, issue_op_d;
    logic [31:0] issue_a_q, issue_a_d;
    logic [31:0] issue_b_q, issue_b_d;
    logic        issue_ill_q, issue_ill_d;

    stage_t      resp_st_q, resp_st_d;
    logic [31:0] resp_z_q, resp_z_d;
    logic [2:0]  resp_flags_q, resp_flags_d;
    logic        resp_ill_q, resp_ill_d;

    logic [15:0] count_q, count_d;

    alu_op_t     dec_op;
    logic        dec_illegal;
    logic        issue_valid, resp_valid;
    logic        resp_load, req_accept, rsp_fire, res_zero;

    alu_issue_dec u_dec (
        .req_func  (req_func),
        .op_o      (dec_op),
        .illegal_o (dec_illegal)
    );

    assign issue_valid = (issue_st_q == ST_HOLD);
    assign resp_valid  = (resp_st_q == ST_HOLD);
    assign resp_load   = issue_valid && (!resp_valid || rsp_ready);
    // ISSUE frees up in the same cycle it drains, so a full pipe still
    // accepts whenever the consumer is taking the head response.
    assign req_ready   = !issue_valid || resp_load;
    assign req_accept  = req_valid && req_ready;
    assign rsp_fire    = resp_valid && rsp_ready;

    // ALU inputs are quiet (AND of zeros) whenever ISSUE is empty.
    assign alu_op   = issue_valid ? issue_op_q : ALU_AND;
    assign alu_x    = issue_valid ? issue_a_q  : 32'd0;
    assign alu_y    = issue_valid ? issue_b_q  : 32'd0;
    assign res_zero = ~|alu_z;

    assign rsp_valid   = resp_valid;
    assign rsp_z       = resp_z_q;
    assign rsp_flags   = resp_flags_q;
    assign rsp_illegal = resp_ill_q;
    assign op_count    = count_q;

    // Next-state for both stages and the completion counter.
    always_comb begin
        issue_st_d   = issue_st_q;
        issue_op_d   = issue_op_q;
        issue_a_d    = issue_a_q;
        issue_b_d    = issue_b_q;
        issue_ill_d  = issue_ill_q;
        resp_st_d    = resp_st_q;
        resp_z_d     = resp_z_q;
        resp_flags_d = resp_flags_q;
        resp_ill_d   = resp_ill_q;
        count_d      = count_q;

        if (req_accept) begin
            issue_st_d  = ST_HOLD;
            issue_op_d  = dec_op;
            issue_a_d   = req_a;
            issue_b_d   = req_b;
            issue_ill_d = dec_illegal;
        end else if (resp_load) begin
            issue_st_d  = ST_EMPTY;
        end

        if (resp_load) begin
            resp_st_d    = ST_HOLD;
            resp_ill_d   = issue_ill_q;
            resp_z_d     = 32'd0;
            resp_flags_d = 3'b000;
            if (!issue_ill_q) begin
                resp_z_d                 = alu_z;
                resp_flags_d[FLAG_OVF]   = alu_overflow;
                resp_flags_d[FLAG_EQUAL] = alu_equal;
                resp_flags_d[FLAG_ZERO]  = res_zero;
            end
        end else if (rsp_fire) begin
            resp_st_d = ST_EMPTY;
        end

        if (rsp_fire) begin
            count_d = count_q + 16'd1;
        end
    end

    // Stage and counter registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_st_q   <= ST_EMPTY;
            issue_op_q   <= ALU_AND;
            issue_a_q    <= 32'd0;
            issue_b_q    <= 32'd0;
            issue_ill_q  <= 1'b0;
            resp_st_q    <= ST_EMPTY;
            resp_z_q     <= 32'd0;
            resp_flags_q <= 3'b000;
            resp_ill_q   <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            issue_st_q   <= issue_st_d;
            issue_op_q   <= issue_op_d;
            issue_a_q    <= issue_a_d;
            issue_b_q    <= issue_b_d;
            issue_ill_q  <= issue_ill_d;
            resp_st_q    <= resp_st_d;
            resp_z_q     <= resp_z_d;
            resp_flags_q <= resp_flags_d;
            resp_ill_q   <= resp_ill_d;
            count_q      <= count_d;
        end
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Sticky overflow: set by a consumed overflow response, clear has priority.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_clear) begin
            sticky_d = 1'b0;
        end else if (rsp_fire && resp_flags_q[FLAG_OVF]) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_func;
    logic [31:0] req_a, req_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_x, alu_y;
    logic [31:0] alu_z;
    logic        alu_overflow, alu_equal;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic [2:0]  rsp_flags;
    logic        rsp_illegal;
    logic [15:0] op_count;
`ifdef ALU_ISSUE_STICKY_OVF_EN
    logic        ovf_clear;
    logic        ovf_sticky;
`endif

    always #5 clk = ~clk;

    alu_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_func     (req_func),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_op       (alu_op),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_z        (alu_z),
        .alu_overflow (alu_overflow),
        .alu_equal    (alu_equal),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_z        (rsp_z),
        .rsp_flags    (rsp_flags),
        .rsp_illegal  (rsp_illegal),
        .op_count     (op_count)
`ifdef ALU_ISSUE_STICKY_OVF_EN
        ,
        .ovf_clear    (ovf_clear),
        .ovf_sticky   (ovf_sticky)
`endif
    );

    // External ALU: combinational from the op/operands the DUT drives.
    always_comb begin
        logic [31:0] r;
        r            = 32'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: r = alu_x & alu_y;
            3'b001: begin
                r = alu_x + alu_y;
                alu_overflow = (alu_x[31] == alu_y[31]) && (r[31] != alu_x[31]);
            end
            3'b010: begin
                r = alu_x - alu_y;
                alu_overflow = (alu_x[31] != alu_y[31]) && (r[31] != alu_x[31]);
            end
            default: r = 32'hDEAD_BEEF;
        endcase
        alu_z     = r;
        alu_equal = (alu_x == alu_y);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] z;
        logic [2:0]  flags;
        logic        ill;
    } resp_t;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [2:0]  flags;
        logic        ill;
    } vec_t;

    typedef struct {
        resp_t r;
        int    acc;
    } item_t;

    // Reference: signed arithmetic in 64 bits; overflow when the 32-bit
    // result does not represent the true sum/difference.
    function automatic resp_t ref_resp(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        resp_t  r;
        longint sa, sb, s;
        r.z = 32'd0; r.flags = 3'b000; r.ill = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        case (f)
            4'd0: r.z = a & b;
            4'd1: begin s = sa + sb; r.z = s[31:0]; r.flags[2] = (s != longint'($signed(r.z))); end
            4'd2: begin s = sa - sb; r.z = s[31:0]; r.flags[2] = (s != longint'($signed(r.z))); end
            default: r.ill = 1'b1;
        endcase
        if (!r.ill) begin
            r.flags[1] = (a == b);
            r.flags[0] = (r.z == 32'd0);
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
`ifdef ALU_ISSUE_STICKY_OVF_EN
        ovf_clear = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t  vecs[8];
    item_t q[$];
    resp_t bexp[4];

    initial begin
        int          exp_cnt;
        int          sent, recv;
        bit          stall, fire, bad;
        logic        exp_valid, exp_ready, fire_in, fire_out, exp_sticky;
        resp_t       nr;
        int          cyc;

        vecs[0] = '{4'h1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b100, 1'b0};
        vecs[1] = '{4'h2, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b011, 1'b0};
        vecs[2] = '{4'hF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 3'b000, 1'b1};
        vecs[3] = '{4'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b000, 1'b0};
        vecs[4] = '{4'h2, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b100, 1'b0};
        vecs[5] = '{4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b001, 1'b0};
        vecs[6] = '{4'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 3'b010, 1'b0};
        vecs[7] = '{4'h3, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 3'b000, 1'b1};

        req_func = 4'd0; req_a = 32'd0; req_b = 32'd0;
        do_reset();

        // Reset state (checked during an active reset pulse).
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_z", rsp_z, 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_x", alu_x, 32'd0);
        chk("rst_alu_y", alu_y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single requests, exact two-cycle latency, rsp_ready high.
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_func = vecs[i].func; req_a = vecs[i].a; req_b = vecs[i].b;
            rsp_ready = 1'b1;
            #1;
            chk($sformatf("tab%0d_ready", i), 32'(req_ready), 32'd1);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk($sformatf("tab%0d_early_valid", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("tab%0d_alu_x", i), alu_x, vecs[i].a);
            @(negedge clk);
            #1;
            chk($sformatf("tab%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("tab%0d_z", i), rsp_z, vecs[i].z);
            chk($sformatf("tab%0d_flags", i), 32'(rsp_flags), 32'(vecs[i].flags));
            chk($sformatf("tab%0d_ill", i), 32'(rsp_illegal), 32'(vecs[i].ill));
            chk($sformatf("tab%0d_count", i), 32'(op_count), 32'(exp_cnt));
            exp_cnt++;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("tab_final_count", 32'(op_count), 32'(exp_cnt));

        // Back-to-back 4 requests with rsp_ready low for the first 3 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) bexp[i] = ref_resp(4'd1, 32'(i * 16 + 1), 32'(i));
        sent = 0; recv = 0; stall = 0;
        for (int c = 0; c < 40 && recv < 4; c++) begin
            @(negedge clk);
            req_valid = (sent < 4);
            req_func  = 4'd1;
            req_a     = 32'(sent * 16 + 1);
            req_b     = 32'(sent);
            rsp_ready = (c >= 3);
            #1;
            if (!req_ready) stall = 1;
            fire = 0;
            if (rsp_valid && rsp_ready) begin
                chk($sformatf("b2b_z%0d", recv), rsp_z, bexp[recv].z);
                chk($sformatf("b2b_flags%0d", recv), 32'(rsp_flags), 32'(bexp[recv].flags));
                fire = 1;
            end
            @(posedge clk);
            if (req_valid && req_ready) sent++;
            if (fire) recv++;
        end
        chk("b2b_received", 32'(recv), 32'd4);
        chk("b2b_saw_stall", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("b2b_op_count", 32'(op_count), 32'd4);
        chk("b2b_no_extra", 32'(rsp_valid), 32'd0);

        // Reset with both stages full.
        @(negedge clk);
        req_valid = 1'b1; req_func = 4'd1; req_a = 32'd10; req_b = 32'd20;
        @(negedge clk);
        req_a = 32'd30; req_b = 32'd40;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_z", rsp_z, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) bad = 1;
        end
        chk("midrst_no_stale", 32'(bad), 32'd0);
        chk("midrst_count_after", 32'(op_count), 32'd0);

`ifdef ALU_ISSUE_STICKY_OVF_EN
        // Sticky overflow set, then clear coincident with a second overflow.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_func = 4'd1; req_a = 32'h7FFF_FFFF; req_b = 32'd1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("stk_before", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        #1;
        chk("stk_set", 32'(ovf_sticky), 32'd1);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ovf_clear = 1'b1;
        #1;
        chk("stk_second_valid", 32'(rsp_valid), 32'd1);
        chk("stk_second_ovf", 32'(rsp_flags), 32'b100);
        @(negedge clk);
        ovf_clear = 1'b0;
        #1;
        chk("stk_clear_wins", 32'(ovf_sticky), 32'd0);
`endif

        // Randomized traffic against a queue-based model.
        do_reset();
        q.delete();
        exp_cnt = 0; exp_sticky = 1'b0; cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) req_func = 4'($urandom_range(3, 15));
            else                           req_func = 4'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: begin req_a = $urandom; req_b = req_a; end
                1: begin req_a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)); req_b = 32'($urandom_range(0, 31)); end
                2: begin req_a = 32'h8000_0000 + 32'($urandom_range(0, 15)); req_b = 32'($urandom_range(0, 31)); end
                default: begin req_a = $urandom; req_b = $urandom; end
            endcase
            rsp_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_ISSUE_STICKY_OVF_EN
            ovf_clear = ($urandom_range(0, 15) == 0);
`endif
            #1;
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
            exp_ready = (q.size() < 2) || rsp_ready;
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rnd_rsp_z", rsp_z, q[0].r.z);
                chk("rnd_rsp_flags", 32'(rsp_flags), 32'(q[0].r.flags));
                chk("rnd_rsp_illegal", 32'(rsp_illegal), 32'(q[0].r.ill));
            end
            chk("rnd_op_count", 32'(op_count), 32'(exp_cnt & 16'hFFFF));
`ifdef ALU_ISSUE_STICKY_OVF_EN
            chk("rnd_sticky", 32'(ovf_sticky), 32'(exp_sticky));
`endif
            fire_in  = req_valid && exp_ready;
            fire_out = exp_valid && rsp_ready;
            nr       = ref_resp(req_func, req_a, req_b);
            @(posedge clk);
`ifdef ALU_ISSUE_STICKY_OVF_EN
            if (ovf_clear) exp_sticky = 1'b0;
            else if (fire_out && q[0].r.flags[2]) exp_sticky = 1'b1;
`endif
            if (fire_out) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (fire_in) q.push_back('{nr, cyc});
            cyc++;
        end

        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
